// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
//   load, load_val, start, stop, en, auto_reload, ack : controller -> timer
//   count, tc, busy, done                             : timer -> controller/consumers
// master = controlling FSM side, slave = timer side.
interface countdown_timer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             en;
    logic             auto_reload;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, stop, en, auto_reload, ack,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, load_val, start, stop, en, auto_reload, ack,
        output count, tc, busy, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control, one-cycle terminal-count
// pulse and a done/ack handshake. Supports one-shot and auto-reload modes.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : countdown_timer_if.slave (control inputs, count/tc/busy/done outputs)
// All outputs are registered.
module countdown_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state / next-output logic; priority load > stop > ack > start > en.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = (bus.start && (bus.load_val != '0)) ? ST_RUN : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!bus.stop && !bus.ack && bus.start && (count_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_IDLE;
                    end else if (bus.en) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                            state_d = bus.auto_reload ? ST_RUN : ST_DONE;
                        end else begin
                            // Zero is only held in RUN between a tc and its reload.
                            if (!bus.auto_reload) begin
                                state_d = ST_DONE;
                            end else if (reload_q == '0) begin
                                state_d = ST_IDLE;
                            end else begin
                                count_d = reload_q;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

    localparam int unsigned WIDTH = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    countdown_timer_if #(.WIDTH(WIDTH)) tif ();

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst             = 1'b0;
        tif.load        = 1'b0;
        tif.load_val    = '0;
        tif.start       = 1'b0;
        tif.stop        = 1'b0;
        tif.en          = 1'b0;
        tif.auto_reload = 1'b0;
        tif.ack         = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tif.load = 1'b1; tif.load_val = 16'd5; tif.start = 1'b1;
        step();
        n_checks++;
        if (tif.count !== 16'd5 || tif.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_preload: count=%0d busy=%b required count=5 busy=1", tif.count, tif.busy);
        end
        rst = 1'b1; tif.en = 1'b1;
        step();
        n_checks++;
        if (tif.count !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_count: got %0d required 0", tif.count);
        end
        n_checks++;
        if ({tif.tc, tif.busy, tif.done} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags: tc/busy/done=%b required 000", {tif.tc, tif.busy, tif.done});
        end
        idle_inputs();
        step();
    endtask

    task automatic test_oneshot();
        logic [15:0] exp_cnt [3] = '{16'd2, 16'd1, 16'd0};
        tif.load = 1'b1; tif.load_val = 16'd3; tif.start = 1'b1;
        step();
        tif.load = 1'b0; tif.start = 1'b0; tif.en = 1'b1;
        n_checks++;
        if (tif.count !== 16'd3 || tif.busy !== 1'b1 || tif.tc !== 1'b0) begin
            n_errors++;
            $display("FAIL oneshot_load: count=%0d busy=%b tc=%b required 3 1 0", tif.count, tif.busy, tif.tc);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (tif.count !== exp_cnt[i] || tif.tc !== (i == 2) || tif.done !== (i == 2)) begin
                n_errors++;
                $display("FAIL oneshot_step%0d: count=%0d tc=%b done=%b required %0d %b %b",
                         i, tif.count, tif.tc, tif.done, exp_cnt[i], (i == 2), (i == 2));
            end
        end
        step();
        n_checks++;
        if (tif.count !== 16'd0 || tif.tc !== 1'b0 || tif.done !== 1'b1 || tif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL oneshot_hold: count=%0d tc=%b done=%b busy=%b required 0 0 1 0",
                     tif.count, tif.tc, tif.done, tif.busy);
        end
        tif.en = 1'b0; tif.ack = 1'b1;
        step();
        tif.ack = 1'b0;
        n_checks++;
        if (tif.done !== 1'b0 || tif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL oneshot_ack: done=%b busy=%b required 0 0", tif.done, tif.busy);
        end
    endtask

    task automatic test_auto_reload();
        logic [15:0] exp_cnt [6] = '{16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2};
        logic        exp_tc  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        tog_en  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] tog_cnt [5] = '{16'd1, 16'd1, 16'd0, 16'd0, 16'd2};
        logic        tog_tc  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tif.auto_reload = 1'b1;
        tif.load = 1'b1; tif.load_val = 16'd2; tif.start = 1'b1;
        step();
        tif.load = 1'b0; tif.start = 1'b0; tif.en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (tif.count !== exp_cnt[i] || tif.tc !== exp_tc[i] || tif.done !== 1'b0 || tif.busy !== 1'b1) begin
                n_errors++;
                $display("FAIL auto_step%0d: count=%0d tc=%b done=%b busy=%b required %0d %b 0 1",
                         i, tif.count, tif.tc, tif.done, tif.busy, exp_cnt[i], exp_tc[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tif.en = tog_en[i];
            step();
            n_checks++;
            if (tif.count !== tog_cnt[i] || tif.tc !== tog_tc[i]) begin
                n_errors++;
                $display("FAIL auto_toggle%0d: count=%0d tc=%b required %0d %b",
                         i, tif.count, tif.tc, tog_cnt[i], tog_tc[i]);
            end
        end
        tif.en = 1'b0; tif.stop = 1'b1;
        step();
        tif.stop = 1'b0; tif.auto_reload = 1'b0;
        n_checks++;
        if (tif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL auto_stop: busy=%b required 0", tif.busy);
        end
    endtask

    task automatic test_stop_resume();
        logic [15:0] exp_cnt [3] = '{16'd2, 16'd1, 16'd0};
        tif.load = 1'b1; tif.load_val = 16'd5; tif.start = 1'b1;
        step();
        tif.load = 1'b0; tif.start = 1'b0; tif.en = 1'b1;
        step();
        step();
        n_checks++;
        if (tif.count !== 16'd3) begin
            n_errors++;
            $display("FAIL stop_pre: count=%0d required 3", tif.count);
        end
        tif.stop = 1'b1;
        step();
        tif.stop = 1'b0;
        n_checks++;
        if (tif.count !== 16'd3 || tif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_hold: count=%0d busy=%b required 3 0", tif.count, tif.busy);
        end
        step();
        n_checks++;
        if (tif.count !== 16'd3 || tif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_idle_en: count=%0d busy=%b required 3 0", tif.count, tif.busy);
        end
        tif.en = 1'b0; tif.start = 1'b1;
        step();
        tif.start = 1'b0; tif.en = 1'b1;
        n_checks++;
        if (tif.count !== 16'd3 || tif.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL resume_start: count=%0d busy=%b required 3 1", tif.count, tif.busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (tif.count !== exp_cnt[i] || tif.tc !== (i == 2)) begin
                n_errors++;
                $display("FAIL resume_step%0d: count=%0d tc=%b required %0d %b",
                         i, tif.count, tif.tc, exp_cnt[i], (i == 2));
            end
        end
        tif.en = 1'b0; tif.ack = 1'b1;
        step();
        tif.ack = 1'b0;
    endtask

    task automatic test_midrun_load();
        tif.load = 1'b1; tif.load_val = 16'd10; tif.start = 1'b1;
        step();
        tif.load = 1'b0; tif.start = 1'b0; tif.en = 1'b1;
        step(); step(); step();
        n_checks++;
        if (tif.count !== 16'd7) begin
            n_errors++;
            $display("FAIL midload_pre: count=%0d required 7", tif.count);
        end
        tif.load = 1'b1; tif.load_val = 16'h0010;
        step();
        tif.load = 1'b0;
        n_checks++;
        if (tif.count !== 16'h0010 || tif.busy !== 1'b0 || tif.tc !== 1'b0) begin
            n_errors++;
            $display("FAIL midload: count=%h busy=%b tc=%b required 0010 0 0", tif.count, tif.busy, tif.tc);
        end
        step();
        n_checks++;
        if (tif.count !== 16'h0010 || tif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midload_idle: count=%h busy=%b required 0010 0", tif.count, tif.busy);
        end
        tif.en = 1'b0;
        tif.load = 1'b1; tif.load_val = 16'd0; tif.start = 1'b1;
        step();
        tif.load = 1'b0;
        n_checks++;
        if (tif.count !== 16'd0 || tif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL load_zero_start: count=%0d busy=%b required 0 0", tif.count, tif.busy);
        end
        step();
        tif.start = 1'b0;
        n_checks++;
        if (tif.count !== 16'd0 || tif.busy !== 1'b0 || tif.done !== 1'b0) begin
            n_errors++;
            $display("FAIL start_zero: count=%0d busy=%b done=%b required 0 0 0", tif.count, tif.busy, tif.done);
        end
    endtask

    task automatic test_full_range();
        logic seen_tc;
        seen_tc = 1'b0;
        tif.load = 1'b1; tif.load_val = 16'hFFFF; tif.start = 1'b1;
        step();
        tif.load = 1'b0; tif.start = 1'b0; tif.en = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            step();
            if (tif.tc === 1'b1) seen_tc = 1'b1;
            if (i == 32766) begin
                n_checks++;
                if (tif.count !== 16'h8000) begin
                    n_errors++;
                    $display("FAIL full_mid: count=%h required 8000", tif.count);
                end
            end
        end
        n_checks++;
        if (tif.count !== 16'd1 || seen_tc !== 1'b0) begin
            n_errors++;
            $display("FAIL full_pre: count=%0d early_tc=%b required 1 0", tif.count, seen_tc);
        end
        step();
        n_checks++;
        if (tif.count !== 16'd0 || tif.tc !== 1'b1 || tif.done !== 1'b1) begin
            n_errors++;
            $display("FAIL full_tc: count=%0d tc=%b done=%b required 0 1 1", tif.count, tif.tc, tif.done);
        end
        tif.en = 1'b0; tif.ack = 1'b1;
        step();
        tif.ack = 1'b0;
    endtask

    task automatic test_reset_midrun();
        tif.load = 1'b1; tif.load_val = 16'h8001; tif.start = 1'b1;
        step();
        tif.load = 1'b0; tif.start = 1'b0; tif.en = 1'b1;
        step();
        n_checks++;
        if (tif.count !== 16'h8000 || tif.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_pre: count=%h busy=%b required 8000 1", tif.count, tif.busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (tif.count !== 16'd0 || {tif.tc, tif.busy, tif.done} !== 3'b000) begin
            n_errors++;
            $display("FAIL rstmid: count=%h tc/busy/done=%b required 0000 000", tif.count, {tif.tc, tif.busy, tif.done});
        end
        tif.start = 1'b1;
        step();
        tif.start = 1'b0;
        n_checks++;
        if (tif.count !== 16'd0 || tif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_reload_cleared: count=%h busy=%b required 0000 0", tif.count, tif.busy);
        end
        tif.en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_stop_resume();
        test_midrun_load();
        test_full_range();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable 16-bit down-counter with a control state machine, terminal-count pulse and a done/ack handshake. It is the counterpart of the existing up-counting `count` next-state block: `count` increments or loads a value, and this block loads a value and counts it down to zero under enable. It sits between a control FSM, which loads the value, starts the count and acknowledges completion, and any logic that consumes the terminal-count pulse.

## Interface
- `WIDTH`, default 16: counter and load-value width.
- `clk`  input  1  rising-edge clock; all state changes on this edge.
- `rst`  input  1  synchronous active-high reset.
- `load`  input  1  captures `load_val` into both the counter and the reload register.
- `load_val`  input  WIDTH  value to load.
- `start`  input  1  requests IDLE -> RUN.
- `stop`  input  1  requests RUN -> IDLE; the count value is held.
- `en`  input  1  count-enable qualifier; only effective in RUN.
- `auto_reload`  input  1  when 1, the counter reloads on reaching zero (periodic mode); when 0, it stops (one-shot mode). Sampled every cycle.
- `ack`  input  1  acknowledges completion; DONE -> IDLE.
- `count`  output  WIDTH  current counter value, registered.
- `tc`  output  1  one-cycle terminal-count pulse, registered.
- `busy`  output  1  high exactly when the state is RUN.
- `done`  output  1  high exactly when the state is DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `count` = 0, reload register = 0, `tc` = 0, `busy` = 0, `done` = 0.
- Input priority, highest first: `rst`, `load`, `stop`, `ack`, `start`, `en`.
- `load`, accepted in any state:
  - `count` <= `load_val` and reload register <= `load_val`.
  - Next state is RUN if `start` is also high and `load_val` != 0; otherwise IDLE.
  - `tc` is 0 in the following cycle.
- IDLE:
  - `start` with `count` != 0 -> RUN.
  - `start` with `count` == 0 is ignored.
  - `en` has no effect.
- RUN, `stop` = 1: -> IDLE. `count` is held, and `en` in the same cycle is ignored.
- RUN, `en` = 1, `count` > 1: `count` <= `count` - 1.
- RUN, `en` = 1, `count` == 1:
  - `count` <= 0 and `tc` <= 1.
  - If `auto_reload` = 0, next state is DONE; otherwise the state stays RUN.
- RUN, `en` = 1, `count` == 0: this is reachable only in auto-reload mode. `count` <= reload register and the state stays RUN.
  - If the reload register is 0, the state goes to IDLE instead.
  - If `auto_reload` was cleared while `count` == 0, the state goes to DONE without asserting `tc`.
- RUN, `en` = 0: `count` holds.
- DONE:
  - `count` holds at 0.
  - `ack` -> IDLE.
  - `start` is ignored.
  - `load` overrides per the load rules above.
- Arithmetic: unsigned modulo 2^WIDTH, but decrement below 0 never occurs.
- A `load_val` of all ones (0xFFFF at the default width) is legal.
- Period in auto-reload mode: N+1 enabled cycles per `tc` for a loaded value N. The counter visits N, N-1, ..., 0, then N again.

## Timing
- All outputs are registered and change only on the `clk` edge. There are no combinational input-to-output paths.
- `tc` is high in the cycle in which `count` first reads 0 after a decrement. It is never high for two consecutive cycles.
- `done` rises in the same cycle as that `tc` pulse in one-shot mode. It stays high until the edge that samples `ack` = 1 (or `load` = 1), then falls.
- `busy` rises one cycle after `start` is accepted, and falls one cycle after `stop`, DONE entry or `load` without `start`.
- Decrement latency: `count` reflects an `en` sample on the next edge.
- Reset mid-count: the state is fully cleared on the next edge regardless of other inputs. Outputs take their reset values; `tc` is 0.

## Test plan
- Reset with `load`, `start` and `en` all high -> after the edge: `count` = 0, IDLE, `tc` = `busy` = `done` = 0.
- `load_val` = 3 with `load` + `start`, then `en` held high, one-shot -> `count` reads 3, 2, 1, 0. `tc` and `done` rise with `count` = 0, `tc` falls one cycle later, `done` holds. `ack` -> IDLE, `done` = 0.
- `load_val` = 2 with `auto_reload` = 1 and `en` held high -> `count` reads 2, 1, 0, 2, 1, 0, with `tc` high on every `count` = 0 cycle (every 3 cycles) and `done` never set. With `en` toggled 1, 0, 1, 0, the cadence doubles.
- `load_val` = 5, count to 3, assert `stop` together with `en` -> `count` holds 3 and the state is IDLE. A subsequent `start` resumes the count: 2, 1, 0.
- Mid-run `load` of 0x0010 while `count` = 7 -> `count` = 0x0010 and the state is IDLE with no `tc`. `load` of 0 + `start` -> remains IDLE. `start` with `count` = 0 -> ignored.
- `load_val` = 0xFFFF one-shot: after 65535 enabled cycles, `count` = 0 and `tc` pulses. Reset asserted mid-run at `count` = 0x8000 -> all outputs return to their reset values on the next edge.
